// File: rtl/dma_frame_sequencer.sv
// Multi-channel, multi-frame launcher for rdma/wdma engine pairs. A single host start runs
// every enabled engine pair for cfg_num_frames frames, with addresses generated per frame.
module dma_frame_sequencer #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 32,
    parameter int unsigned FRM_W  = 16
) (
    input  logic                     ap_clk,
    input  logic                     areset,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic [FRM_W-1:0]         cfg_num_frames,
    input  logic [NUM_CH-1:0]        cfg_ch_en,
    input  logic                     cfg_soft_stop,
    input  logic [ADDR_W-1:0]        cfg_rd_base,
    input  logic [ADDR_W-1:0]        cfg_wr_base,
    input  logic [ADDR_W-1:0]        cfg_ch_offset,
    input  logic [ADDR_W-1:0]        cfg_frm_stride,
    input  logic [LEN_W-1:0]         cfg_rd_bytes,
    input  logic [LEN_W-1:0]         cfg_wr_bytes,
    output logic [NUM_CH-1:0]        rdma_start,
    input  logic [NUM_CH-1:0]        rdma_ready,
    input  logic [NUM_CH-1:0]        rdma_done,
    output logic [NUM_CH*ADDR_W-1:0] rdma_addr,
    output logic [LEN_W-1:0]         rdma_bytes,
    output logic [NUM_CH-1:0]        wdma_start,
    input  logic [NUM_CH-1:0]        wdma_ready,
    input  logic [NUM_CH-1:0]        wdma_done,
    output logic [NUM_CH*ADDR_W-1:0] wdma_addr,
    output logic [LEN_W-1:0]         wdma_bytes,
    output logic [FRM_W-1:0]         frame_idx,
    output logic [31:0]              run_cycles
);

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StNext, StDone} state_e;

    state_e state_q, state_d;

    logic                     ap_start_r;
    logic                     ap_done_q;
    logic                     ap_idle_q;
    logic [FRM_W-1:0]         num_frames_q;
    logic [NUM_CH-1:0]        ch_en_q;
    logic [ADDR_W-1:0]        rd_base_q;
    logic [ADDR_W-1:0]        wr_base_q;
    logic [ADDR_W-1:0]        ch_offset_q;
    logic [ADDR_W-1:0]        frm_stride_q;
    logic [ADDR_W-1:0]        frame_base_q;
    logic [LEN_W-1:0]         rd_bytes_q;
    logic [LEN_W-1:0]         wr_bytes_q;
    logic                     stop_q;
    logic [NUM_CH-1:0]        rd_start_q;
    logic [NUM_CH-1:0]        wr_start_q;
    logic [NUM_CH-1:0]        rd_done_q;
    logic [NUM_CH-1:0]        wr_done_q;
    logic [FRM_W-1:0]         frame_idx_q;
    logic [31:0]              run_cycles_q;
    logic [NUM_CH*ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_CH*ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]        off_acc;

    logic start_edge;
    logic zero_run;
    logic all_done;
    logic last_frame;

    assign start_edge = ap_start & ~ap_start_r;
    assign zero_run   = (cfg_num_frames == '0) || (cfg_ch_en == '0);
    assign last_frame = (frame_idx_q == num_frames_q - FRM_W'(1));
    // Disabled engines count as finished; a start still awaiting ready blocks completion.
    assign all_done   = (&(rd_done_q | ~ch_en_q)) && (&(wr_done_q | ~ch_en_q)) &&
                        ((rd_start_q | wr_start_q) == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_edge) state_d = zero_run ? StDone : StLaunch;
            StLaunch: state_d = StWait;
            StWait:   if (all_done) state_d = StNext;
            StNext:   state_d = (last_frame || stop_q) ? StDone : StLaunch;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        off_acc   = '0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_addr_d[c*ADDR_W +: ADDR_W] = rd_base_q + off_acc + frame_base_q;
            wr_addr_d[c*ADDR_W +: ADDR_W] = wr_base_q + off_acc + frame_base_q;
            off_acc = off_acc + ch_offset_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            ap_start_r   <= 1'b0;
            ap_done_q    <= 1'b0;
            ap_idle_q    <= 1'b1;
            num_frames_q <= '0;
            ch_en_q      <= '0;
            rd_base_q    <= '0;
            wr_base_q    <= '0;
            ch_offset_q  <= '0;
            frm_stride_q <= '0;
            frame_base_q <= '0;
            rd_bytes_q   <= '0;
            wr_bytes_q   <= '0;
            stop_q       <= 1'b0;
            rd_start_q   <= '0;
            wr_start_q   <= '0;
            rd_done_q    <= '0;
            wr_done_q    <= '0;
            frame_idx_q  <= '0;
            run_cycles_q <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
        end else begin
            ap_start_r <= ap_start;
            ap_done_q  <= (state_q == StDone);
            ap_idle_q  <= (state_q == StIdle);
            if (state_q != StIdle && run_cycles_q != '1) run_cycles_q <= run_cycles_q + 32'd1;

            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        num_frames_q <= cfg_num_frames;
                        ch_en_q      <= cfg_ch_en;
                        rd_base_q    <= cfg_rd_base;
                        wr_base_q    <= cfg_wr_base;
                        ch_offset_q  <= cfg_ch_offset;
                        frm_stride_q <= cfg_frm_stride;
                        rd_bytes_q   <= cfg_rd_bytes;
                        wr_bytes_q   <= cfg_wr_bytes;
                        frame_base_q <= '0;
                        frame_idx_q  <= '0;
                        stop_q       <= 1'b0;
                        // The edge cycle itself is the first cycle of the run.
                        run_cycles_q <= 32'd1;
                    end
                end
                StLaunch: begin
                    rd_addr_q  <= rd_addr_d;
                    wr_addr_q  <= wr_addr_d;
                    rd_start_q <= ch_en_q;
                    wr_start_q <= ch_en_q;
                    rd_done_q  <= '0;
                    wr_done_q  <= '0;
                end
                StWait: begin
                    rd_start_q <= rd_start_q & ~(rdma_ready & ch_en_q);
                    wr_start_q <= wr_start_q & ~(wdma_ready & ch_en_q);
                    rd_done_q  <= rd_done_q | (rdma_done & ch_en_q);
                    wr_done_q  <= wr_done_q | (wdma_done & ch_en_q);
                    if (cfg_soft_stop) stop_q <= 1'b1;
                end
                StNext: begin
                    if (!(last_frame || stop_q)) begin
                        frame_idx_q  <= frame_idx_q + FRM_W'(1);
                        frame_base_q <= frame_base_q + frm_stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_done    = ap_done_q;
    assign ap_ready   = ap_done_q;
    assign ap_idle    = ap_idle_q;
    assign rdma_start = rd_start_q;
    assign wdma_start = wr_start_q;
    assign rdma_addr  = rd_addr_q;
    assign wdma_addr  = wr_addr_q;
    assign rdma_bytes = rd_bytes_q;
    assign wdma_bytes = wr_bytes_q;
    assign frame_idx  = frame_idx_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_dma_frame_sequencer.sv
// Bench for dma_frame_sequencer: behavioural engines, per-launch address scoreboard and a table
// of runs with expected frame counts and run lengths, plus reset and held-start sequences.
module tb_dma_frame_sequencer;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int FW  = 16;

    logic ap_clk = 1'b0;
    logic areset = 1'b1;
    logic ap_start = 1'b0;
    logic ap_done, ap_idle, ap_ready;
    logic [FW-1:0] cfg_num_frames = '0;
    logic [NCH-1:0] cfg_ch_en = '0;
    logic cfg_soft_stop;
    logic [AW-1:0] cfg_rd_base = '0, cfg_wr_base = '0, cfg_ch_offset = '0, cfg_frm_stride = '0;
    logic [LW-1:0] cfg_rd_bytes = '0, cfg_wr_bytes = '0;
    logic [NCH-1:0] rdma_start, rdma_ready, rdma_done, wdma_start, wdma_ready, wdma_done;
    logic [NCH*AW-1:0] rdma_addr, wdma_addr;
    logic [LW-1:0] rdma_bytes, wdma_bytes;
    logic [FW-1:0] frame_idx;
    logic [31:0] run_cycles;

    dma_frame_sequencer #(.NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .FRM_W(FW)) dut (
        .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .cfg_num_frames(cfg_num_frames),
        .cfg_ch_en(cfg_ch_en), .cfg_soft_stop(cfg_soft_stop), .cfg_rd_base(cfg_rd_base),
        .cfg_wr_base(cfg_wr_base), .cfg_ch_offset(cfg_ch_offset),
        .cfg_frm_stride(cfg_frm_stride), .cfg_rd_bytes(cfg_rd_bytes),
        .cfg_wr_bytes(cfg_wr_bytes), .rdma_start(rdma_start), .rdma_ready(rdma_ready),
        .rdma_done(rdma_done), .rdma_addr(rdma_addr), .rdma_bytes(rdma_bytes),
        .wdma_start(wdma_start), .wdma_ready(wdma_ready), .wdma_done(wdma_done),
        .wdma_addr(wdma_addr), .wdma_bytes(wdma_bytes), .frame_idx(frame_idx),
        .run_cycles(run_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int frames; logic [NCH-1:0] en;
        logic [AW-1:0] rd_base, wr_base, off, stride; logic [LW-1:0] rb, wb;
        int rdy, wr0_rdy, dly, rd0_dly, wr0_dly, stop_frame; bit garbage;
        int exp_frames, exp_cycles;
    } vec_t;

    typedef struct {
        logic [FW-1:0] frm; logic [NCH-1:0] en;
        logic [NCH*AW-1:0] rd, wr; logic [LW-1:0] rb, wb; bit stop;
    } sb_t;

    vec_t vecs[9];
    sb_t  sb[$];

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, launch_cnt = 0, viol_cnt = 0, start_cyc = 0, done_cyc = 0;
    int rd_rdy_d[NCH], wr_rdy_d[NCH], rd_dly_d[NCH], wr_dly_d[NCH];
    int rd_ph[NCH], wr_ph[NCH], rd_cnt[NCH], wr_cnt[NCH], rd_len[NCH], wr_len[NCH];
    bit cur_garbage = 1'b0;
    bit len_chk = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int frames, input logic [NCH-1:0] en,
        input logic [AW-1:0] rdb, input logic [AW-1:0] wrb, input logic [AW-1:0] off,
        input logic [AW-1:0] stride, input int rdy, input int wr0_rdy, input int dly,
        input int rd0_dly, input int wr0_dly, input int stop_frame, input bit garbage,
        input int exp_frames, input int exp_cycles);
        vec_t v;
        v.frames = frames; v.en = en; v.rd_base = rdb; v.wr_base = wrb; v.off = off;
        v.stride = stride; v.rb = 32'h40 + rdb[11:0]; v.wb = 32'h80 + wrb[11:0];
        v.rdy = rdy; v.wr0_rdy = wr0_rdy; v.dly = dly; v.rd0_dly = rd0_dly;
        v.wr0_dly = wr0_dly; v.stop_frame = stop_frame; v.garbage = garbage;
        v.exp_frames = exp_frames; v.exp_cycles = exp_cycles;
        return v;
    endfunction

    // Engine handshake model: ready after rdy cycles of start, done dly cycles after ready.
    task automatic eng_step(input logic start, input int rdy, input int dly, inout int ph,
                            inout int cnt, output logic r, output logic d);
        r = 1'b0; d = 1'b0;
        if (ph == 0 && start) begin ph = 1; cnt = 0; end
        if (ph == 1) begin
            if (cnt == rdy) begin
                r = 1'b1; ph = 2; cnt = 0;
                if (dly == 0) begin d = 1'b1; ph = 0; end
            end else cnt++;
        end else if (ph == 2) begin
            cnt++;
            if (cnt == dly) begin d = 1'b1; ph = 0; end
        end
    endtask

    // Engines, launch scoreboard and protocol monitor, all sampled on the falling edge.
    initial begin
        logic [2*NCH-1:0] starts_prev;
        logic st_prev;
        sb_t rec;
        int p, k;
        logic r, d;
        starts_prev = '0; st_prev = 1'b0;
        rdma_ready = '0; rdma_done = '0; wdma_ready = '0; wdma_done = '0;
        cfg_soft_stop = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rd_ph[c] = 0; wr_ph[c] = 0; rd_cnt[c] = 0; wr_cnt[c] = 0; rd_len[c] = 0; wr_len[c] = 0;
        end
        forever begin
            @(negedge ap_clk);
            cyc++;
            cfg_soft_stop = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (areset) begin
                    rd_ph[c] = 0; wr_ph[c] = 0;
                    rdma_ready[c] = 1'b0; rdma_done[c] = 1'b0;
                    wdma_ready[c] = 1'b0; wdma_done[c] = 1'b0;
                end else if (!cfg_ch_en[c] && cur_garbage) begin
                    rdma_ready[c] = 1'($urandom_range(0, 1)); rdma_done[c] = 1'($urandom_range(0, 1));
                    wdma_ready[c] = 1'($urandom_range(0, 1)); wdma_done[c] = 1'($urandom_range(0, 1));
                end else begin
                    p = rd_ph[c]; k = rd_cnt[c];
                    eng_step(rdma_start[c], rd_rdy_d[c], rd_dly_d[c], p, k, r, d);
                    rd_ph[c] = p; rd_cnt[c] = k; rdma_ready[c] = r; rdma_done[c] = d;
                    p = wr_ph[c]; k = wr_cnt[c];
                    eng_step(wdma_start[c], wr_rdy_d[c], wr_dly_d[c], p, k, r, d);
                    wr_ph[c] = p; wr_cnt[c] = k; wdma_ready[c] = r; wdma_done[c] = d;
                end
                if (rdma_start[c]) rd_len[c]++;
                else if (rd_len[c] != 0) begin
                    if (len_chk) chk("rdma_start_len", 64'(rd_len[c]), 64'(rd_rdy_d[c] + 1));
                    rd_len[c] = 0;
                end
                if (wdma_start[c]) wr_len[c]++;
                else if (wr_len[c] != 0) begin
                    if (len_chk) chk("wdma_start_len", 64'(wr_len[c]), 64'(wr_rdy_d[c] + 1));
                    wr_len[c] = 0;
                end
            end
            if (((rdma_start | wdma_start) & ~cfg_ch_en) != '0) viol_cnt++;
            if (ap_ready != ap_done) viol_cnt++;
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("idle_at_done", 64'(ap_idle), 64'd0);
            end
            if (ap_start && !st_prev) start_cyc = cyc;
            st_prev = ap_start;
            if ({wdma_start, rdma_start} != '0 && starts_prev == '0) begin
                launch_cnt++;
                if (sb.size() == 0) chk("unexpected_launch", 64'(sb.size()), 64'd1);
                else begin
                    rec = sb.pop_front();
                    chk("launch_frame_idx", 64'(frame_idx), 64'(rec.frm));
                    chk("launch_rd_mask", 64'(rdma_start), 64'(rec.en));
                    chk("launch_wr_mask", 64'(wdma_start), 64'(rec.en));
                    chk("rdma_bytes", 64'(rdma_bytes), 64'(rec.rb));
                    chk("wdma_bytes", 64'(wdma_bytes), 64'(rec.wb));
                    for (int c = 0; c < NCH; c++) begin
                        if (rec.en[c]) begin
                            chk("rdma_addr", 64'(rdma_addr[c*AW +: AW]), 64'(rec.rd[c*AW +: AW]));
                            chk("wdma_addr", 64'(wdma_addr[c*AW +: AW]), 64'(rec.wr[c*AW +: AW]));
                        end
                    end
                    if (rec.stop) cfg_soft_stop = 1'b1;
                end
            end
            starts_prev = {wdma_start, rdma_start};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge ap_clk); #2; end
    endtask

    task automatic setup_vec(input vec_t v);
        sb_t rec;
        cfg_num_frames = FW'(v.frames); cfg_ch_en = v.en;
        cfg_rd_base = v.rd_base; cfg_wr_base = v.wr_base; cfg_ch_offset = v.off;
        cfg_frm_stride = v.stride; cfg_rd_bytes = v.rb; cfg_wr_bytes = v.wb;
        cur_garbage = v.garbage;
        for (int c = 0; c < NCH; c++) begin
            rd_rdy_d[c] = v.rdy;
            wr_rdy_d[c] = (c == 0) ? v.wr0_rdy : v.rdy;
            rd_dly_d[c] = (c == 0) ? v.rd0_dly : v.dly;
            wr_dly_d[c] = (c == 0) ? v.wr0_dly : v.dly;
        end
        for (int f = 0; f < v.exp_frames; f++) begin
            rec.frm = FW'(f); rec.en = v.en; rec.rb = v.rb; rec.wb = v.wb;
            rec.stop = (f == v.stop_frame);
            for (int c = 0; c < NCH; c++) begin
                rec.rd[c*AW +: AW] = v.rd_base + 32'(c) * v.off + 32'(f) * v.stride;
                rec.wr[c*AW +: AW] = v.wr_base + 32'(c) * v.off + 32'(f) * v.stride;
            end
            sb.push_back(rec);
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int d0, l0, v0;
        setup_vec(v);
        d0 = done_cnt; l0 = launch_cnt; v0 = viol_cnt;
        tick(1);
        ap_start = 1'b1;
        tick(hold);
        ap_start = 1'b0;
        for (int k = 0; k < 3000 && done_cnt == d0; k++) tick(1);
        tick(6);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("done_latency", 64'(done_cyc - start_cyc), 64'(v.exp_cycles));
        chk("run_cycles", 64'(run_cycles), 64'(v.exp_cycles));
        chk("final_frame_idx", 64'(frame_idx), 64'(v.exp_frames > 0 ? v.exp_frames - 1 : 0));
        chk("launch_count", 64'(launch_cnt - l0), 64'(v.exp_frames));
        chk("sb_left", 64'(sb.size()), 64'd0);
        chk("protocol_viol", 64'(viol_cnt - v0), 64'd0);
        chk("idle_after", 64'(ap_idle), 64'd1);
        sb.delete();
    endtask

    initial begin
        int d0, l0;
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0;
        // frames, en, rd_base, wr_base, offset, stride, rdy, wr0_rdy, dly, rd0_dly, wr0_dly,
        // stop_frame, garbage, exp_frames, exp_cycles (2 + frames*(max(rdy+dly)+4))
        vecs[0] = mk(3, 2'b11, 32'h1000, 32'h8000, 32'h100, 32'h400, 1, 1, 10, 10, 10, -1, 0, 3, 47);
        vecs[1] = mk(2, 2'b01, 32'h2000, 32'h9000, 32'h40, 32'h800, 1, 1, 4, 4, 4, -1, 1, 2, 20);
        vecs[2] = mk(2, 2'b11, 32'h0, 32'h4000, 32'h10, 32'h20, 1, 5, 3, 3, 3, -1, 0, 2, 26);
        vecs[3] = mk(2, 2'b11, 32'h3000, 32'h5000, 32'h200, 32'h1000, 1, 1, 10, 0, 12, -1, 0, 2, 36);
        vecs[4] = mk(0, 2'b11, 32'h1000, 32'h8000, 32'h100, 32'h400, 1, 1, 2, 2, 2, -1, 0, 0, 2);
        vecs[5] = mk(5, 2'b11, 32'h100, 32'h200, 32'h8, 32'h10, 1, 1, 2, 2, 2, 1, 0, 2, 16);
        vecs[6] = mk(4, 2'b00, 32'h100, 32'h200, 32'h8, 32'h10, 1, 1, 2, 2, 2, -1, 0, 0, 2);
        vecs[7] = mk(2, 2'b10, 32'hFFFFFF00, 32'h7FFFFFF0, 32'h80, 32'h100, 1, 1, 2, 2, 2, -1, 0,
                     2, 16);
        vecs[8] = mk(1, 2'b11, 32'h500, 32'h600, 32'h4, 32'h4, 0, 0, 0, 0, 0, -1, 0, 1, 6);

        tick(3);
        areset = 1'b0;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_starts", 64'({rdma_start, wdma_start}), 64'd0);
        chk("rst_rd_addr", 64'(rdma_addr), 64'd0);
        chk("rst_wr_addr", 64'(wdma_addr), 64'd0);
        chk("rst_bytes", 64'({rdma_bytes, wdma_bytes}), 64'd0);
        chk("rst_frame_idx", 64'(frame_idx), 64'd0);
        chk("rst_run_cycles", 64'(run_cycles), 64'd0);
        tick(2);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1);

        // Held start: one run only.
        run_vec(vecs[8], 100);

        // Reset in the middle of WAIT.
        setup_vec(vecs[0]);
        len_chk = 1'b0;
        l0 = launch_cnt;
        tick(1);
        ap_start = 1'b1;
        tick(1);
        ap_start = 1'b0;
        for (int k = 0; k < 100 && launch_cnt == l0; k++) tick(1);
        tick(3);
        chk("pre_rst_busy", 64'(ap_idle), 64'd0);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        d0 = done_cnt;
        chk("midrst_idle", 64'(ap_idle), 64'd1);
        chk("midrst_starts", 64'({rdma_start, wdma_start}), 64'd0);
        chk("midrst_run_cycles", 64'(run_cycles), 64'd0);
        tick(60);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midrst_starts_stay", 64'({rdma_start, wdma_start}), 64'd0);
        sb.delete();
        len_chk = 1'b1;

        run_vec(vecs[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
